// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches aligned 64-bit words into a halfword ring
// buffer, decodes V850 instruction lengths and presents one instruction per cycle.
module ifetch_queue #(
  parameter int unsigned     PC_W     = 25,
  parameter int unsigned     DEPTH_HW = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic            mem_req_o,
  output logic [PC_W-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [63:0]     mem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [63:0]     inst_o,
  output logic [1:0]      inst_len_o,
  output logic [PC_W-1:0] inst_pc_o
);

  localparam int unsigned      PTR_W       = $clog2(DEPTH_HW);
  localparam int unsigned      CNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0] REQ_MAX_CNT = CNT_W'(DEPTH_HW - 4);
  localparam logic [PC_W-1:0]  RESET_FPC   = RESET_PC & ~(PC_W'(3));

  logic [15:0]      hw_q [DEPTH_HW];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  head_pc_q, head_pc_d;
  logic [1:0]       skip_q, skip_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;

  logic [15:0]      head_hw;
  logic [1:0]       dec_len;
  logic [CNT_W-1:0] len_hw;
  logic [CNT_W-1:0] fill_hw;
  logic             grant;
  logic             fill;
  logic             pop;

  // Request whenever nothing is in flight and a full word is guaranteed to fit;
  // both terms are registered, so the request holds until granted.
  assign mem_req_o  = !reset && !outstanding_q && (count_q <= REQ_MAX_CNT);
  assign mem_addr_o = fetch_pc_q;

  assign grant   = mem_req_o && mem_gnt_i;
  assign fill    = mem_rvalid_i && !drop_q && !redirect_i;
  assign fill_hw = CNT_W'(3'd4 - {1'b0, skip_q});
  assign pop     = inst_valid_o && inst_ready_i;

  assign head_hw = hw_q[head_q];

  // Length decode of the head halfword (0=16, 1=32, 2=48, 3=64 bit)
  always_comb begin
    dec_len = 2'd1;
    if (head_hw[10:9] != 2'b11) begin
      dec_len = (head_hw[15:11] == 5'd0 && head_hw[9] && head_hw[7]) ? 2'd1 : 2'd0;
    end else if (head_hw[8:5] == 4'b1111) begin
      dec_len = 2'd3;
    end else if (head_hw[15:11] == 5'd0 && head_hw[8:6] == 3'b000) begin
      dec_len = 2'd2;
    end
  end

  assign len_hw       = CNT_W'(dec_len) + CNT_W'(1);
  assign inst_valid_o = !reset && !redirect_i && (count_q >= len_hw);

  // Head instruction assembly; halfwords beyond the decoded length read as zero
  always_comb begin
    inst_o     = '0;
    inst_len_o = '0;
    inst_pc_o  = '0;
    if (inst_valid_o) begin
      for (int k = 0; k < 4; k++) begin
        if (2'(k) <= dec_len) begin
          inst_o[16*k +: 16] = hw_q[head_q + PTR_W'(k)];
        end
      end
      inst_len_o = dec_len;
      inst_pc_o  = head_pc_q;
    end
  end

  // Next-state for pointers, fetch PC and handshake tracking; redirect wins
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    skip_d        = skip_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (mem_rvalid_i) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    if (grant) begin
      outstanding_d = 1'b1;
      fetch_pc_d    = fetch_pc_q + PC_W'(4);
    end
    if (fill) begin
      tail_d = tail_q + PTR_W'(fill_hw);
      skip_d = 2'd0;
    end
    count_d = count_q + (fill ? fill_hw : '0) - (pop ? len_hw : '0);
    if (pop) begin
      head_d    = head_q + PTR_W'(len_hw);
      head_pc_d = head_pc_q + PC_W'(len_hw);
    end

    if (redirect_i) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      head_pc_d  = redirect_pc_i;
      fetch_pc_d = redirect_pc_i & ~(PC_W'(3));
      skip_d     = redirect_pc_i[1:0];
      // Any request still in flight after this cycle belongs to the old stream
      drop_d     = outstanding_d;
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_FPC;
      head_pc_q     <= RESET_PC;
      skip_q        <= RESET_PC[1:0];
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      skip_q        <= skip_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Ring buffer write: halfwords skip..3 of the returned word land at the tail
  always_ff @(posedge clk) begin
    if (fill) begin
      for (int k = 0; k < 4; k++) begin
        if (2'(k) >= skip_q) begin
          hw_q[tail_q + PTR_W'(k) - PTR_W'(skip_q)] <= mem_rdata_i[16*k +: 16];
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: memory responder plus a stream-level reference
// model (expected PC sequence from program memory, halfword occupancy, epochs).
module tb_ifetch_queue;

  localparam int unsigned PC_W  = 25;
  localparam int          DEPTH = 16;

  logic            clk;
  logic            reset;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic            mem_req_o;
  logic [PC_W-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [63:0]     mem_rdata_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [63:0]     inst_o;
  logic [1:0]      inst_len_o;
  logic [PC_W-1:0] inst_pc_o;

  ifetch_queue #(.PC_W(PC_W), .DEPTH_HW(DEPTH), .RESET_PC('0)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_len_o    (inst_len_o),
    .inst_pc_o     (inst_pc_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [1:0]      len;
    logic [63:0]     inst;
  } pop_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Program memory: fixed random contents with directed overrides
  logic [63:0] rnd_mem [256];
  logic [63:0] mem_ovr [bit [PC_W-1:0]];

  // Reference model state
  int              occ;
  int              epoch;
  bit              first;
  logic [PC_W-1:0] exp_pc;
  logic [PC_W-1:0] exp_fetch;
  logic [PC_W-1:0] epoch_start;
  bit              resp_valid;
  int              resp_wait;
  int              resp_epoch;
  logic [PC_W-1:0] resp_addr;

  int unsigned gnt_pct, ready_pct, lat_min, lat_max;
  logic        last_valid;
  pop_t        pops[$];
  logic [PC_W-1:0] grants[$];

  function automatic logic [63:0] mem_word(input logic [PC_W-1:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return rnd_mem[a[9:2]];
  endfunction

  function automatic logic [15:0] hw(input logic [PC_W-1:0] a);
    logic [63:0] w;
    w = mem_word(a & ~(PC_W'(3)));
    return w[16*int'(a[1:0]) +: 16];
  endfunction

  function automatic logic [1:0] decode(input logic [15:0] h);
    if (h[10:9] != 2'b11) return (h[15:11] == 5'd0 && h[9] && h[7]) ? 2'd1 : 2'd0;
    if (h[8:5] == 4'hF) return 2'd3;
    if (h[15:11] == 5'd0 && h[8:6] == 3'd0) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [63:0] build(input logic [PC_W-1:0] pc, input logic [1:0] len);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (k <= int'(len)) r[16*k +: 16] = hw(pc + PC_W'(k));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    occ         = 0;
    epoch       = epoch + 1;
    first       = 1'b1;
    exp_pc      = '0;
    exp_fetch   = '0;
    epoch_start = '0;
    resp_valid  = 1'b0;
    resp_wait   = 0;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset        = 1'b1;
      redirect_i   = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      inst_ready_i = 1'b1;
      #1;
      chk("reset_mem_req", 64'(mem_req_o), 64'd0);
      chk("reset_inst_valid", 64'(inst_valid_o), 64'd0);
      chk("reset_inst_o", inst_o, 64'd0);
    end
    @(negedge clk);
    reset        = 1'b0;
    inst_ready_i = 1'b0;
    model_init();
    pops.delete();
    grants.delete();
  endtask

  // One clock cycle: drive memory/consumer, check outputs, advance the model
  task automatic step(input bit redir, input logic [PC_W-1:0] rpc, input int rdy);
    logic       rv, gnt, exp_valid;
    logic [1:0] exp_len;
    pop_t       p;
    @(negedge clk);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    inst_ready_i  = (rdy == 2) ? ($urandom_range(99) < ready_pct) : (rdy == 1);
    rv            = resp_valid && (resp_wait == 0);
    mem_rvalid_i  = rv;
    mem_rdata_i   = rv ? mem_word(resp_addr) : {$urandom, $urandom};
    gnt           = mem_req_o && ($urandom_range(99) < gnt_pct);
    mem_gnt_i     = gnt;
    #1;
    exp_len   = decode(hw(exp_pc));
    exp_valid = !redir && (occ >= int'(exp_len) + 1);
    chk("mem_req_o", 64'(mem_req_o), 64'(!resp_valid && (DEPTH - occ >= 4)));
    chk("inst_valid_o", 64'(inst_valid_o), 64'(exp_valid));
    if (inst_valid_o) begin
      chk("inst_pc_o", 64'(inst_pc_o), 64'(exp_pc));
      chk("inst_len_o", 64'(inst_len_o), 64'(exp_len));
      chk("inst_o", inst_o, build(exp_pc, exp_len));
    end else begin
      chk("idle_inst_o", inst_o, 64'd0);
      chk("idle_len_pc", 64'({inst_len_o, inst_pc_o}), 64'd0);
    end
    if (gnt) chk("mem_addr_o", 64'(mem_addr_o), 64'(exp_fetch));
    last_valid = inst_valid_o;
    if (inst_valid_o && inst_ready_i) begin
      p.pc = inst_pc_o; p.len = inst_len_o; p.inst = inst_o;
      pops.push_back(p);
    end
    if (gnt && !redir) grants.push_back(mem_addr_o);

    if (rv) begin
      if (!redir && resp_epoch == epoch) begin
        occ   = occ + (first ? 4 - int'(epoch_start[1:0]) : 4);
        first = 1'b0;
      end
      resp_valid = 1'b0;
    end else if (resp_valid) begin
      resp_wait = resp_wait - 1;
    end
    if (gnt) begin
      resp_valid = 1'b1;
      resp_addr  = mem_addr_o;
      resp_epoch = epoch;
      resp_wait  = int'($urandom_range(lat_max, lat_min)) - 1;
      exp_fetch  = exp_fetch + PC_W'(4);
    end
    if (exp_valid && inst_ready_i) begin
      occ    = occ - (int'(exp_len) + 1);
      exp_pc = exp_pc + PC_W'(exp_len) + PC_W'(1);
    end
    if (redir) begin
      epoch       = epoch + 1;
      occ         = 0;
      exp_pc      = rpc;
      exp_fetch   = rpc & ~(PC_W'(3));
      epoch_start = rpc;
      first       = 1'b1;
    end
  endtask

  logic [63:0]     snap_inst;
  logic [PC_W-1:0] snap_pc;
  bit              found;

  initial begin
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; inst_ready_i = 1'b0;
    epoch = 0; last_valid = 1'b0; snap_inst = '0; snap_pc = '0; found = 1'b0;
    for (int i = 0; i < 256; i++) rnd_mem[i] = {$urandom, $urandom};
    mem_ovr[25'h000] = 64'h0001_0002_0003_0004;
    mem_ovr[25'h100] = 64'hAAAA_BBBB_CCCC_0FE0;
    mem_ovr[25'h104] = 64'h5555_6666_7777_0F00;
    mem_ovr[25'h108] = 64'h0000_9999_8888_0600;
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;

    // Reset and the basic 16-bit stream at PC 0
    do_reset(3);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1);
    chk("t1_grant_count", 64'(grants.size() >= 2), 64'd1);
    if (grants.size() >= 2) begin
      chk("t1_first_addr", 64'(grants[0]), 64'd0);
      chk("t1_second_addr", 64'(grants[1]), 64'd4);
    end
    chk("t1_pop_count", 64'(pops.size() >= 4), 64'd1);
    if (pops.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_pc", 64'(pops[i].pc), 64'(i));
        chk("t1_inst", pops[i].inst, 64'(4 - i));
        chk("t1_len", 64'(pops[i].len), 64'd0);
      end
    end

    // Mixed 64/32/32/48-bit instructions starting at 0x100
    pops.delete();
    step(1'b1, 25'h100, 1);
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1);
    chk("t2_pop_count", 64'(pops.size() >= 5), 64'd1);
    if (pops.size() >= 5) begin
      chk("t2_len64", 64'(pops[0].len), 64'd3);
      chk("t2_inst64", pops[0].inst, 64'hAAAA_BBBB_CCCC_0FE0);
      chk("t2_pc_after64", 64'(pops[1].pc), 64'h104);
      chk("t2_len32", 64'(pops[1].len), 64'd1);
      chk("t2_inst32", pops[1].inst, 64'h0000_0000_7777_0F00);
      chk("t3_pc48", 64'(pops[3].pc), 64'h108);
      chk("t3_len48", 64'(pops[3].len), 64'd2);
      chk("t3_inst48", pops[3].inst, 64'h0000_9999_8888_0600);
      chk("t3_pc_after48", 64'(pops[4].pc), 64'h10B);
    end

    // Backpressure: consumer stalls 20 cycles, then drains
    pops.delete();
    step(1'b1, 25'h200, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, '0, 0);
      if (i == 8) begin
        chk("t4_valid_held", 64'(inst_valid_o), 64'd1);
        snap_inst = inst_o;
        snap_pc   = inst_pc_o;
      end
    end
    chk("t4_inst_stable", inst_o, snap_inst);
    chk("t4_pc_stable", 64'(inst_pc_o), 64'(snap_pc));
    chk("t4_req_dropped", 64'(mem_req_o), 64'd0);
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1);
    chk("t4_drain_first", (pops.size() > 0) ? 64'(pops[0].pc) : 64'hDEAD, 64'h200);

    // Redirect to 7 while a request is outstanding
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 50 && !resp_valid; i++) step(1'b0, '0, 1);
    chk("t5_outstanding", 64'(resp_valid), 64'd1);
    pops.delete();
    grants.delete();
    step(1'b1, 25'h7, 1);
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1);
    chk("t5_next_addr", (grants.size() > 0) ? 64'(grants[0]) : 64'hDEAD, 64'h4);
    chk("t5_first_pc", (pops.size() > 0) ? 64'(pops[0].pc) : 64'hDEAD, 64'h7);

    // Redirect coinciding with a pop and a live fill
    lat_min = 3; lat_max = 3; ready_pct = 30;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (resp_valid && resp_wait == 0 && resp_epoch == epoch &&
          occ >= int'(decode(hw(exp_pc))) + 1) begin
        found = 1'b1;
        break;
      end
      step(1'b0, '0, 2);
    end
    chk("t6_setup_found", 64'(found), 64'd1);
    pops.delete();
    step(1'b1, 25'h300, 1);
    chk("t6_valid_low", 64'(last_valid), 64'd0);
    chk("t6_no_pop", 64'(pops.size()), 64'd0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1);
    chk("t6_first_pc", (pops.size() > 0) ? 64'(pops[0].pc) : 64'hDEAD, 64'h300);

    // Fetch address wraps past the top of the PC space
    lat_min = 1; lat_max = 1; ready_pct = 100;
    grants.delete();
    step(1'b1, 25'h1FF_FFFC, 1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1);
    chk("t7_grant_count", 64'(grants.size() >= 2), 64'd1);
    if (grants.size() >= 2) begin
      chk("t7_addr_top", 64'(grants[0]), 64'h1FF_FFFC);
      chk("t7_addr_wrap", 64'(grants[1]), 64'd0);
    end

    // Randomized traffic, a mid-run reset, then more traffic
    gnt_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(99) < 2) step(1'b1, PC_W'($urandom), 2);
      else step(1'b0, '0, 2);
    end
    do_reset(2);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(99) < 3) step(1'b1, PC_W'($urandom), 2);
      else step(1'b0, '0, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised instruction prefetch queue and length decoder for the V850 front end.
- Fetches aligned 64-bit words from instruction memory into a halfword ring buffer.
- Decodes 16/32/48/64-bit instruction lengths and presents one instruction per cycle with its PC over a valid/ready handshake.
- Supports pipeline redirects (branch/exception): flushes the queue and discards in-flight fetch data.

Parameters:
- PC_W, 25, width of halfword-granular PC and memory address.
- DEPTH_HW, 16, ring buffer depth in halfwords; power of two, at least 8.
- RESET_PC, 0, halfword PC loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- redirect_i  in  1  flush queue and restart fetch at redirect_pc_i.
- redirect_pc_i  in  PC_W  new halfword PC.
- mem_req_o  out  1  fetch request.
- mem_addr_o  out  PC_W  halfword address of request; bits [1:0] always 0.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  64  four halfwords; [15:0] is the lowest address.
- inst_valid_o  out  1  complete instruction at head.
- inst_ready_i  in  1  consumer accepts.
- inst_o  out  64  instruction, first halfword in [15:0]; bits beyond length are 0.
- inst_len_o  out  2  0=16, 1=32, 2=48, 3=64 bit.
- inst_pc_o  out  PC_W  halfword PC of head instruction.

Behaviour:
- Reset values: count=0, head/tail=0, fetch_pc = RESET_PC & ~3, skip = RESET_PC[1:0], head_pc = RESET_PC, outstanding=0, drop=0.
- Output reset values: mem_req_o=0 and inst_valid_o=0 while reset is high. inst_o, inst_len_o and inst_pc_o are 0 while inst_valid_o=0.
- Fetch rules:
  - At most one request outstanding.
  - mem_req_o=1 when !outstanding and free slots (DEPTH_HW - count) >= 4.
  - Hold mem_req_o and mem_addr_o stable until mem_gnt_i.
  - On grant: outstanding=1 and fetch_pc += 4.
  - mem_rvalid_i arrives at least 1 cycle after the grant.
- Fill rules:
  - On mem_rvalid_i with drop=0, write halfwords skip..3 to the tail, then set skip=0 and outstanding=0.
  - Tail and head pointers wrap modulo DEPTH_HW.
- Length decode of head halfword h (reg2 = h[15:11]), evaluated in order:
  - If h[10:9]!=2'b11 and reg2==0 and h[9] and h[7]: 32 bit (JR/JARL).
  - Else if h[10:9]!=2'b11: 16 bit.
  - Else if h[8:5]==4'b1111: 64 bit.
  - Else if reg2==0 and h[8:6]==3'b000: 48 bit.
  - Else: 32 bit.
- Output rules:
  - inst_valid_o = (count >= len_hw) && !redirect_i.
  - The outputs are combinational from the buffer head and stay stable while valid && !ready.
- Pop:
  - A pop occurs on inst_valid_o && inst_ready_i.
  - head += len_hw, count -= len_hw, head_pc += len_hw.
  - A pop and a fill in the same cycle both apply.
  - Capacity is never exceeded because the request is gated on 4 free slots.
- Redirect (priority over pop and fill in the same cycle):
  - count=0, head=tail=0, head_pc = redirect_pc_i, fetch_pc = redirect_pc_i & ~3, skip = redirect_pc_i[1:0].
  - If outstanding, or a grant occurs this cycle: drop=1. Otherwise drop=0.
  - mem_req_o is deasserted during the redirect cycle only if not yet granted; an already-presented request may complete and will be dropped.
  - A back-to-back redirect re-arms the same rule.
- Dropped response: mem_rvalid_i with drop=1 writes nothing and clears drop and outstanding.
- Arithmetic: all PCs are modulo 2^PC_W halfwords, and wrap from all-ones to 0 silently.
- Reset mid-operation: reset overrides everything. Any later rvalid from a pre-reset request is a memory-side protocol violation and is not covered.

Test Plan:
- Reset, RESET_PC=0, memory returns 0x0001_0002_0003_0004 with all 16-bit encodings:
  - mem_addr_o=0 first, then 4.
  - Four instructions with pc 0,1,2,3 and inst_o 0x0004, 0x0003, 0x0002, 0x0001, each with len 0.
- Mixed lengths: head halfword 0x0FE0 (h[10:9]=11, reg2=1, h[8:6]=111, h[8:5]=1111):
  - len=3 and pc advances by 4.
  - A following 0x0F00 (reg2=1, h[8:6]=100) gives len=1.
- 48-bit case: halfword 0x0600 (reg2=0, h[10:9]=11, h[8:6]=000) gives len=2, inst_o[63:48]=0, and the next pc is +3.
- Backpressure: hold inst_ready_i=0 for 20 cycles:
  - No more than DEPTH_HW halfwords are buffered and mem_req_o drops.
  - inst_o stays stable.
  - Releasing ready drains the queue in order with no loss.
- Redirect to pc 0x000007 while a request is outstanding:
  - The stale rvalid is discarded.
  - The next request address is 0x000004, and halfwords 4..6 are skipped.
  - The first instruction issued has inst_pc_o=0x000007.
- Redirect in the same cycle as inst_ready_i and mem_rvalid_i: no pop is counted, the fill is ignored, and inst_valid_o=0 that cycle.
- Wrap: PC_W=25, redirect to 0x1FFFFFC; after fetching 4 halfwords the fetch address wraps to 0.
